// File: rtl/matmul_ctrl_if.sv
// Command, array and writeback signals of the matrix-multiply controller.
// The slave modport is the controller's view; master is the surrounding pipeline/array.
interface matmul_ctrl_if;
  logic         cmd_valid;
  logic [2:0]   cmd_opcode;
  logic [2:0]   cmd_idx;
  logic         cmd_high_low;
  logic         cmd_ready;
  logic         stall;
  logic         mm_wr_a;
  logic         mm_wr_b;
  logic         mm_wr_c;
  logic [2:0]   mm_row;
  logic         mm_start;
  logic         mm_done;
  logic         mm_rd_en;
  logic [255:0] mm_rd_data;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         err;
  logic         err_clr;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_idx, cmd_high_low, mm_done, mm_rd_data, err_clr,
    output cmd_ready, stall, mm_wr_a, mm_wr_b, mm_wr_c, mm_row, mm_start, mm_rd_en,
           rd_valid, rd_data, err
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_idx, cmd_high_low, mm_done, mm_rd_data, err_clr,
    input  cmd_ready, stall, mm_wr_a, mm_wr_b, mm_wr_c, mm_row, mm_start, mm_rd_en,
           rd_valid, rd_data, err
  );
endinterface

// File: rtl/matmul_ctrl.sv
// Matrix-multiply command controller: accepts one decoded command at a time,
// issues registered row-write / start / read strobes to the array, tracks which
// A/B rows are loaded, watches compute for a timeout and returns C-row halves.
module matmul_ctrl (
  input  logic             clk,
  input  logic             rst,
  matmul_ctrl_if.slave     bus
);

  localparam logic [2:0] OP_WR_A  = 3'b000;
  localparam logic [2:0] OP_WR_B  = 3'b001;
  localparam logic [2:0] OP_WR_C  = 3'b010;
  localparam logic [2:0] OP_START = 3'b011;
  localparam logic [2:0] OP_RD_C  = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, COMPUTE, RD_WAIT} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic           hl_q, hl_d;
  logic           wr_a_q, wr_a_d;
  logic           wr_b_q, wr_b_d;
  logic           wr_c_q, wr_c_d;
  logic           start_q, start_d;
  logic           rd_en_q, rd_en_d;
  logic           rd_valid_q, rd_valid_d;
  logic [2:0]     row_q, row_d;
  logic [127:0]   rd_data_q, rd_data_d;
  logic [7:0]     a_loaded_q, a_loaded_d;
  logic [7:0]     b_loaded_q, b_loaded_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           err_set;
  logic           cmd_ready;
  logic [7:0]     idx_onehot;

  // Row index decoded to a one-hot mask for the loaded-row bitmaps.
  for (genvar gi = 0; gi < 8; gi++) begin : g_idx_dec
    assign idx_onehot[gi] = (bus.cmd_idx == 3'(gi));
  end

  assign cmd_ready     = (state_q == IDLE);
  assign bus.cmd_ready = cmd_ready;
  assign bus.stall     = bus.cmd_valid & ~cmd_ready;
  assign bus.mm_wr_a   = wr_a_q;
  assign bus.mm_wr_b   = wr_b_q;
  assign bus.mm_wr_c   = wr_c_q;
  assign bus.mm_start  = start_q;
  assign bus.mm_rd_en  = rd_en_q;
  assign bus.mm_row    = row_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.err       = err_q;

  // Next-state logic: strobes are computed here one cycle ahead and registered below.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hl_d       = hl_q;
    wr_a_d     = 1'b0;
    wr_b_d     = 1'b0;
    wr_c_d     = 1'b0;
    start_d    = 1'b0;
    rd_en_d    = 1'b0;
    rd_valid_d = 1'b0;
    row_d      = row_q;
    rd_data_d  = rd_data_q;
    a_loaded_d = a_loaded_q;
    b_loaded_d = b_loaded_q;
    cnt_d      = cnt_q;
    err_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_opcode;
          hl_d = bus.cmd_high_low;
          case (bus.cmd_opcode)
            OP_WR_A: begin
              wr_a_d     = 1'b1;
              row_d      = bus.cmd_idx;
              a_loaded_d = a_loaded_q | idx_onehot;
              state_d    = ISSUE;
            end
            OP_WR_B: begin
              wr_b_d     = 1'b1;
              row_d      = bus.cmd_idx;
              b_loaded_d = b_loaded_q | idx_onehot;
              state_d    = ISSUE;
            end
            OP_WR_C: begin
              wr_c_d  = 1'b1;
              row_d   = bus.cmd_idx;
              state_d = ISSUE;
            end
            OP_START: begin
              // Computing with missing operand rows would give garbage; refuse and flag.
              if (a_loaded_q == 8'hFF && b_loaded_q == 8'hFF) begin
                start_d = 1'b1;
                state_d = ISSUE;
              end else begin
                err_set = 1'b1;
              end
            end
            OP_RD_C: begin
              rd_en_d = 1'b1;
              row_d   = bus.cmd_idx;
              state_d = ISSUE;
            end
            default: err_set = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        cnt_d = 8'd0;
        case (op_q)
          OP_START: state_d = COMPUTE;
          OP_RD_C:  state_d = RD_WAIT;
          default:  state_d = IDLE;
        endcase
      end
      COMPUTE: begin
        if (bus.mm_done) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == 8'hFF) begin
          // Array never answered: give up so the pipeline is not wedged forever.
          err_set = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_WAIT: begin
        // Array data arrives the cycle after mm_rd_en, i.e. now.
        rd_data_d  = hl_q ? bus.mm_rd_data[255:128] : bus.mm_rd_data[127:0];
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error: a new error event in the same cycle as a clear must survive.
  assign err_d = (err_q & ~bus.err_clr) | err_set;

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      hl_q       <= 1'b0;
      wr_a_q     <= 1'b0;
      wr_b_q     <= 1'b0;
      wr_c_q     <= 1'b0;
      start_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      row_q      <= 3'd0;
      rd_data_q  <= 128'd0;
      a_loaded_q <= 8'd0;
      b_loaded_q <= 8'd0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hl_q       <= hl_d;
      wr_a_q     <= wr_a_d;
      wr_b_q     <= wr_b_d;
      wr_c_q     <= wr_c_d;
      start_q    <= start_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      row_q      <= row_d;
      rd_data_q  <= rd_data_d;
      a_loaded_q <= a_loaded_d;
      b_loaded_q <= b_loaded_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  decoded matmul command present (matrix multiplier enable from decode).
REQ-005 cmd_opcode  in  3  000 WR_A, 001 WR_B, 010 WR_C, 011 START, 100 RD_C, 101-111 illegal.
REQ-006 cmd_idx  in  3  row index 0-7.
REQ-007 cmd_high_low  in  1  RD_C half select: 1 = bits [255:128], 0 = bits [127:0].
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-009 stall  out  1  cmd_valid & ~cmd_ready (combinational), to pipeline hazard logic.
REQ-010 mm_wr_a / mm_wr_b / mm_wr_c  out  1 each  single-cycle row-write strobes to array.
REQ-011 mm_row  out  3  row index to array, valid with any strobe or mm_rd_en.
REQ-012 mm_start  out  1  single-cycle compute start pulse.
REQ-013 mm_done  in  1  array compute complete, single-cycle pulse.
REQ-014 mm_rd_en  out  1  single-cycle C-row read strobe; array returns data exactly one cycle later.
REQ-015 mm_rd_data  in  256  C row from array.
REQ-016 rd_valid  out  1  single-cycle pulse, rd_data valid to writeback.
REQ-017 rd_data  out  128  registered selected half of C row.
REQ-018 err  out  1  sticky error flag.
REQ-019 err_clr  in  1  clears err.

Function
REQ-020 States SHALL be IDLE, ISSUE, COMPUTE, RD_WAIT; cmd_ready SHALL be 1 only in IDLE.
REQ-021 Accept at cycle T (IDLE, cmd_valid): latch opcode/idx/high_low, enter ISSUE at T+1.
REQ-022 WR_A/WR_B/WR_C: at T+1 matching strobe = 1, mm_row = idx; return to IDLE at T+2.
REQ-023 WR_A/WR_B SHALL set bit idx in 8-bit a_loaded/b_loaded bitmaps; bitmaps persist until rst; rewrites allowed.
REQ-024 START with a_loaded = 8'hFF and b_loaded = 8'hFF: mm_start = 1 at T+1, enter COMPUTE at T+2.
REQ-025 START with either bitmap incomplete: set err, no mm_start, remain IDLE (ready at T+1).
REQ-026 COMPUTE: 8-bit counter from 0, incremented each cycle; mm_done seen at cycle D -> IDLE at D+1.
REQ-027 COMPUTE: counter reaching 255 without mm_done -> set err, return to IDLE next cycle, counter cleared.
REQ-028 mm_done outside COMPUTE SHALL be ignored.
REQ-029 RD_C: mm_rd_en = 1 and mm_row = idx at T+1, enter RD_WAIT at T+2; in RD_WAIT capture mm_rd_data half per latched high_low into rd_data; rd_valid = 1 and state IDLE at T+3.
REQ-030 rd_data SHALL hold its value until the next RD_C capture.
REQ-031 Illegal opcode: accepted, err set, no strobes, remain IDLE.
REQ-032 err_clr and an error event in the same cycle: err SHALL be 1 (set wins).
REQ-033 All strobes, mm_start, mm_rd_en, and rd_valid SHALL be registered, never combinational from cmd inputs.

Reset
REQ-034 On rst: state IDLE, all strobes/mm_start/mm_rd_en/rd_valid = 0, mm_row = 0, rd_data = 0, bitmaps = 0, counter = 0, err = 0; cmd_ready = 1 after release.
REQ-035 rst asserted mid-COMPUTE or mid-RD_WAIT SHALL abort without a further pulse; a later mm_done SHALL be ignored.

Verification
REQ-036 WR_A idx=3 accepted at T -> mm_wr_a = 1, mm_row = 3 at T+1 only; cmd_ready 0 at T+1, 1 at T+2.
REQ-037 START after only 7 A rows loaded -> err = 1 at T+1, no mm_start; err_clr -> err = 0.
REQ-038 Load 8 A and 8 B rows, START, mm_done 10 cycles after mm_start -> stall high throughout, cmd_ready 1 cycle after mm_done.
REQ-039 START with mm_done never asserted -> err = 1 after 255 COMPUTE cycles; IDLE next cycle.
REQ-040 RD_C idx=5, high_low=1, mm_rd_data = {128'hA..., 128'hB...} -> mm_rd_en at T+1, rd_valid at T+3, rd_data = upper half.
REQ-041 rst pulse during COMPUTE, then mm_done -> no err, bitmaps 0, IDLE, cmd_ready 1.
